w_clk_module_full: RTL and testbench

Write-domain half of the asynchronous FIFO; the counterpart of the read-side pointer/empty logic.
- Owns the write pointer, both binary and Gray-coded.
- Generates the write address for the dual-port memory.
- Brings the read pointer into w_clk through a two-flop synchronizer and produces a registered, conservative w_full.
- Reports writes rejected while full as a one-cycle w_overflow pulse.

---
 rtl/w_clk_module_full_pkg.sv | 30 +++
 rtl/w_clk_module_full_if.sv | 46 ++++
 rtl/w_clk_module_full_sync.sv | 37 +++
 rtl/w_clk_module_full.sv | 114 +++++++++++
 tb/tb_w_clk_module_full.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/w_clk_module_full_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for both halves of the asynchronous FIFO: the default
// address width, the derived pointer width and the Gray/binary conversions.
// The conversions operate on a 32-bit container. Callers zero-extend the
// pointer in and truncate the result back out, so one function serves any
// pointer width up to 32 bits.
// Optional feature macro used by the including blocks: W_ALMOST_FULL_EN.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDRESS_SIZE_DEF = 4;
  localparam int PTR_W_DEF        = ADDRESS_SIZE_DEF + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down. Upper zero-extended bits leave the result
  // unchanged, which keeps this valid for narrower pointers.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/w_clk_module_full_if.sv
// -----------------------------------------------------------------------------
// w_clk_module_full_if
// Write-side bundle of the asynchronous FIFO.
//   w_en          write request from the producer
//   r_ptr         Gray read pointer arriving from the read domain
//   w_ptr         registered Gray write pointer sent to the read domain
//   w_addr        binary write address for the dual-port memory
//   w_full        registered full flag
//   w_overflow    one-cycle pulse for a write rejected while full
//   w_almost_full / w_count   exist only with W_ALMOST_FULL_EN
// Modports: master = producer/environment side, slave = write-pointer block.
// -----------------------------------------------------------------------------
interface w_clk_module_full_if #(
  parameter int ADDRESS_SIZE = fifo_pkg::ADDRESS_SIZE_DEF
);

  logic                    w_en;
  logic [ADDRESS_SIZE:0]   r_ptr;
  logic [ADDRESS_SIZE:0]   w_ptr;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic                    w_full;
  logic                    w_overflow;
`ifdef W_ALMOST_FULL_EN
  logic                    w_almost_full;
  logic [ADDRESS_SIZE:0]   w_count;

  modport master (
    output w_en, r_ptr,
    input  w_ptr, w_addr, w_full, w_overflow, w_almost_full, w_count
  );
  modport slave (
    input  w_en, r_ptr,
    output w_ptr, w_addr, w_full, w_overflow, w_almost_full, w_count
  );
`else
  modport master (
    output w_en, r_ptr,
    input  w_ptr, w_addr, w_full, w_overflow
  );
  modport slave (
    input  w_en, r_ptr,
    output w_ptr, w_addr, w_full, w_overflow
  );
`endif

endinterface

// File: rtl/w_clk_module_full_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff_w
// Two-flop synchronizer for a Gray-coded pointer crossing into clk. Only one
// bit of a Gray pointer changes per step, so the captured value is always
// either the old or the new pointer. The read side reuses this block.
//   clk    destination clock
//   rst_n  asynchronous active-low reset; both stages clear to 0
//   d      asynchronous input
//   q      synchronized output, second stage
// -----------------------------------------------------------------------------
module sync_2ff_w #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage1;
  logic [WIDTH-1:0] r_stage2;

  // NOTE: non-blocking assignments make both stages sample their pre-edge
  // inputs; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= d;
      r_stage2 <= r_stage1;
    end
  end

  assign q = r_stage2;

endmodule

// File: rtl/w_clk_module_full.sv
// -----------------------------------------------------------------------------
// w_clk_module_full
// Write-domain half of the asynchronous FIFO. This block owns the binary and
// Gray write pointers and drives the memory write address. It synchronizes the
// read pointer into w_clk and produces a registered, conservative full flag.
// A write rejected while full is reported as a one-cycle overflow pulse.
// Optional feature macro: W_ALMOST_FULL_EN, which adds w_count and
// w_almost_full.
//   w_clk   write clock
//   wrst_n  asynchronous active-low reset
//   bus     w_clk_module_full_if.slave (see the interface for signal list)
// Parameters: ADDRESS_SIZE (>= 2), MEMORY_DEPTH (== 2**ADDRESS_SIZE),
//             AF_THRESHOLD (free slots at/below which almost-full asserts).
// -----------------------------------------------------------------------------
module w_clk_module_full
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int MEMORY_DEPTH = 16,
  parameter int AF_THRESHOLD = 2
) (
  input  logic                  w_clk,
  input  logic                  wrst_n,
  w_clk_module_full_if.slave    bus
);

  localparam int A  = ADDRESS_SIZE;
  localparam int PW = ADDRESS_SIZE + 1;

  // Elaboration-time guards on the configuration.
  if (ADDRESS_SIZE < 2) begin : g_bad_asize
    $error("ADDRESS_SIZE must be >= 2");
  end
  if (MEMORY_DEPTH != (1 << ADDRESS_SIZE)) begin : g_bad_depth
    $error("MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
  end
  if (AF_THRESHOLD > MEMORY_DEPTH) begin : g_bad_af
    $error("AF_THRESHOLD must not exceed MEMORY_DEPTH");
  end

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_full;
  logic          r_overflow;

  logic [PW-1:0] w_wq2_rptr;
  logic [PW-1:0] w_bnext;
  logic [PW-1:0] w_gnext;
  logic          w_write;
  logic          w_full_next;

  sync_2ff_w #(.WIDTH(PW)) u_sync_rptr (
    .clk   (w_clk),
    .rst_n (wrst_n),
    .d     (bus.r_ptr),
    .q     (w_wq2_rptr)
  );

  assign w_write = bus.w_en & ~r_full;
  assign w_bnext = r_wbin + PW'(w_write);
  assign w_gnext = PW'(bin2gray(32'(w_bnext)));

  // The FIFO is full when the write pointer has lapped the read pointer once.
  // In Gray code that means the top two bits differ and the rest match.
  // Comparing against the synchronized, possibly stale read pointer can only
  // keep the flag high too long, never drop it early.
  assign w_full_next = (w_gnext == {~w_wq2_rptr[A:A-1], w_wq2_rptr[A-2:0]});

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin     <= '0;
      r_wptr     <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wbin     <= w_bnext;
      r_wptr     <= w_gnext;
      r_full     <= w_full_next;
      r_overflow <= bus.w_en & r_full;
    end
  end

  assign bus.w_ptr      = r_wptr;
  assign bus.w_addr     = r_wbin[A-1:0];
  assign bus.w_full     = r_full;
  assign bus.w_overflow = r_overflow;

`ifdef W_ALMOST_FULL_EN
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_count_next;
  logic          w_af_next;
  logic [PW-1:0] r_count;
  logic          r_almost_full;

  // Decoding happens only after the second synchronizer stage.
  assign w_rbin_s     = PW'(gray2bin(32'(w_wq2_rptr)));
  assign w_count_next = w_bnext - w_rbin_s;
  assign w_af_next    = (MEMORY_DEPTH - int'(w_count_next)) <= AF_THRESHOLD;

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_almost_full <= w_af_next;
    end
  end

  assign bus.w_count       = r_count;
  assign bus.w_almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_w_clk_module_full.sv
// -----------------------------------------------------------------------------
// tb_w_clk_module_full
// Directed stimulus for the write-domain FIFO pointer block. Each stimulus step
// queues the outputs expected after its clock edge. A separate monitor drains
// the queue on the falling edge, or on an explicit event for the asynchronous
// reset check, and compares the queued values with the DUT outputs.
// Almost-full/count fields are compared only when W_ALMOST_FULL_EN is defined.
// -----------------------------------------------------------------------------
module tb_w_clk_module_full;
  import fifo_pkg::*;

  typedef struct {
    logic [4:0] ptr;
    logic [3:0] addr;
    logic       full;
    logic       ovf;
    logic       af;
    logic [4:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;

  w_clk_module_full_if #(.ADDRESS_SIZE(4)) bus ();

  w_clk_module_full #(
    .ADDRESS_SIZE (4),
    .MEMORY_DEPTH (16),
    .AF_THRESHOLD (2)
  ) dut (
    .w_clk  (clk),
    .wrst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] p, input logic [3:0] a,
                              input logic f, input logic o,
                              input logic af, input logic [4:0] c);
    exp_t e;
    e.ptr = p; e.addr = a; e.full = f; e.ovf = o; e.af = af; e.cnt = c;
    return e;
  endfunction

  function automatic logic [4:0] gray5(input int b);
    return 5'(b ^ (b >> 1));
  endfunction

  task automatic push(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock: drive inputs, take the rising edge, queue expected outputs.
  task automatic cycle(input logic en, input logic [4:0] rp,
                       input exp_t e, input string nm);
    bus.w_en  = en;
    bus.r_ptr = rp;
    @(posedge clk);
    #1;
    push(e, nm);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".w_ptr"},      32'(bus.w_ptr),      32'(e.ptr));
        check({nm, ".w_addr"},     32'(bus.w_addr),     32'(e.addr));
        check({nm, ".w_full"},     32'(bus.w_full),     32'(e.full));
        check({nm, ".w_overflow"}, 32'(bus.w_overflow), 32'(e.ovf));
`ifdef W_ALMOST_FULL_EN
        check({nm, ".w_almost_full"}, 32'(bus.w_almost_full), 32'(e.af));
        check({nm, ".w_count"},       32'(bus.w_count),       32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.w_en  = 1'b0;
    bus.r_ptr = 5'b00000;

    // Outputs must be zero while reset is held.
    push(mk(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0), "rst_hold");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(1'b0, 5'b00000, mk(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0), "post_rst");

    // Fill from empty with the read pointer parked at 0.
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 5'b00000,
            mk(gray5(k), 4'(k), k == 16, 1'b0, k >= 14, 5'(k)),
            $sformatf("fill%0d", k));
    end

    // Write attempt while full, then idle: pulse lasts one cycle.
    cycle(1'b1, 5'b00000, mk(5'b11000, 4'd0, 1'b1, 1'b1, 1'b1, 5'd16), "ovf");
    cycle(1'b0, 5'b00000, mk(5'b11000, 4'd0, 1'b1, 1'b0, 1'b1, 5'd16), "ovf_clear");

    // Read side frees one slot: full drops on the third edge.
    cycle(1'b0, 5'b00001, mk(5'b11000, 4'd0, 1'b1, 1'b0, 1'b1, 5'd16), "rel_e1");
    cycle(1'b0, 5'b00001, mk(5'b11000, 4'd0, 1'b1, 1'b0, 1'b1, 5'd16), "rel_e2");
    cycle(1'b0, 5'b00001, mk(5'b11000, 4'd0, 1'b0, 1'b0, 1'b1, 5'd15), "rel_e3");

    // Reader catches up to binary 16 (Gray 11000), then one write wraps.
    cycle(1'b0, 5'b11000, mk(5'b11000, 4'd0, 1'b0, 1'b0, 1'b1, 5'd15), "wrap_s1");
    cycle(1'b0, 5'b11000, mk(5'b11000, 4'd0, 1'b0, 1'b0, 1'b1, 5'd15), "wrap_s2");
    cycle(1'b1, 5'b11000, mk(5'b11001, 4'd1, 1'b0, 1'b0, 1'b0, 5'd1), "wrap_wr");

    // Burst up to w_addr = 7.
    for (int k = 18; k <= 23; k++) begin
      cycle(1'b1, 5'b11000,
            mk(gray5(k), 4'(k), 1'b0, 1'b0, 1'b0, 5'(k - 16)),
            $sformatf("burst%0d", k));
    end

    // Asynchronous reset mid-burst, checked before the next rising edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.r_ptr = 5'b00000;
    #1;
    push(mk(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0), "mid_rst");
    -> chk_ev;
    bus.w_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    cycle(1'b1, 5'b00000, mk(5'b00001, 4'd1, 1'b0, 1'b0, 1'b0, 5'd1), "post_mid1");
    cycle(1'b1, 5'b00000, mk(5'b00011, 4'd2, 1'b0, 1'b0, 1'b0, 5'd2), "post_mid2");
    bus.w_en = 1'b0;

    // Give the monitor a bounded window to drain the queue.
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending checks", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
